// File: rtl/onchip_pixel_streamer_if.sv
// Command, memory-read and pixel-stream signals of the on-chip pixel streamer.
interface onchip_pixel_streamer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PIX_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    input  start, base_addr, word_count, mem_readdata, pix_ready,
    output busy, done, mem_address, mem_chipselect, mem_clken, pix_data, pix_valid
  );

  modport slave (
    output start, base_addr, word_count, mem_readdata, pix_ready,
    input  busy, done, mem_address, mem_chipselect, mem_clken, pix_data, pix_valid
  );
endinterface

// File: rtl/onchip_pixel_streamer.sv
// Reads a run of words from on-chip line memory and streams them out as
// RGB565 pixel pairs through a 2-word buffer.
module onchip_pixel_streamer #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PIX_W     = 16,
  parameter bit          LOW_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  onchip_pixel_streamer_if.master bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              inflight;
  logic [DATA_W-1:0] fifo [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_count;
  logic              half;
  logic              busy_q;
  logic              done_q;

  logic              issue;
  logic              xfer;
  logic              pop;
  logic              last_pop;
  logic [DATA_W-1:0] head;

  // Issue only when the buffer plus the word in flight leaves room for the reply.
  always_comb begin
    issue    = (state == RUN) && (remaining != '0) &&
               ((32'(fifo_count) + 32'(inflight)) < 32'd2);
    xfer     = (fifo_count != 2'd0) && bus.pix_ready;
    pop      = xfer && half;
    last_pop = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop);
    head     = fifo[rd_ptr];
  end

  assign bus.mem_address    = addr;
  assign bus.mem_chipselect = issue;
  assign bus.mem_clken      = busy_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pix_valid      = (fifo_count != 2'd0);
  assign bus.pix_data       = (half == LOW_FIRST) ? head[DATA_W-1 -: PIX_W] : head[PIX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      half       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      inflight <= issue;

      // Memory data is valid the cycle after the issue.
      if (inflight) begin
        fifo[wr_ptr] <= bus.mem_readdata;
        wr_ptr       <= ~wr_ptr;
      end

      // Second half of a word pops it and returns the select to the first half.
      if (xfer) half <= ~half;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(inflight) - 2'(pop);

      case (state)
        RUN: begin
          if ((remaining == '0) && !inflight && last_pop) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            addr      <= bus.base_addr;
            remaining <= bus.word_count;
            if (bus.word_count == '0) begin
              state  <= FINISH;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
